// File: rtl/hdmi_tx_pio_pkg.sv
// hdmi_tx_pio_pkg: register map, state encoding and constants shared by the HDMI TX interrupt servicer
package hdmi_tx_pio_pkg;
   localparam logic [1:0]  PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0]  PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0]  PIO_ADDR_CAP  = 2'd3;
   localparam logic [31:0] CAP_CLEAR     = 32'h1;
   typedef enum logic [3:0] {
      INIT,
      IDLE,
      RD_CAP,
      RD_CAP_W,
      RD_DAT,
      RD_DAT_W,
      CLR,
      EMIT,
      HOLD
   } svc_state_t;
endpackage

// File: rtl/avm_single_access.sv
// avm_single_access: issues one registered Avalon-MM read or write and flags completion after the fixed read latency
module avm_single_access #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        wr,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [1:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   output logic [31:0] rdata,
   output logic        done
);
   logic [3:0] lat;
   // One-cycle strobe; address and data hold until the next access so the read wait cycle keeps a stable address
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         avm_address    <= 2'd0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_writedata  <= 32'h0;
         lat            <= 4'd0;
      end else begin
         avm_chipselect <= start;
         avm_write_n    <= !(start && wr);
         if (start) begin
            avm_address   <= addr;
            avm_writedata <= wdata;
         end
         lat <= (start && !wr) ? 4'(READ_LATENCY + 1) : (lat != 4'd0) ? lat - 4'd1 : 4'd0;
      end
   assign rdata = avm_readdata;
   assign done  = (avm_chipselect && !avm_write_n) || (lat == 4'd1);
endmodule

// File: rtl/hdmi_tx_int_servicer.sv
// hdmi_tx_int_servicer: Avalon-MM master that arms and services the HDMI TX interrupt PIO and emits one event per capture
module hdmi_tx_int_servicer
   import hdmi_tx_pio_pkg::*;
#(
   parameter int          COUNT_W      = 16,
   parameter logic [31:0] MASK_VALUE   = 32'h1,
   parameter int          READ_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               irq,
   output logic [1:0]         avm_address,
   output logic               avm_chipselect,
   output logic               avm_write_n,
   output logic [31:0]        avm_writedata,
   input  logic [31:0]        avm_readdata,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic               evt_level,
   output logic [COUNT_W-1:0] evt_count,
   output logic [7:0]         spurious_count,
   output logic               busy
);
   svc_state_t  state_q, state_d;
   logic        acc_start, acc_wr, acc_done;
   logic [1:0]  acc_addr;
   logic [31:0] acc_wdata, acc_rdata;
   logic        spur_inc, lvl_ld, evt_acc;
   logic        unused_rdata;
   assign unused_rdata = ^acc_rdata[31:1];

   avm_single_access #(
      .READ_LATENCY (READ_LATENCY)
   ) u_acc (
      .clk            (clk),
      .reset          (reset),
      .start          (acc_start),
      .wr             (acc_wr),
      .addr           (acc_addr),
      .wdata          (acc_wdata),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write_n    (avm_write_n),
      .avm_writedata  (avm_writedata),
      .avm_readdata   (avm_readdata),
      .rdata          (acc_rdata),
      .done           (acc_done)
   );

   // State register; reset lands in INIT so the mask is re-armed after every reset
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= INIT;
      else       state_q <= state_d;

   // Next state and access requests; each access is launched on the transition into its request state
   always_comb begin
      state_d   = state_q;
      acc_start = 1'b0;
      acc_wr    = 1'b0;
      acc_addr  = PIO_ADDR_CAP;
      acc_wdata = 32'h0;
      spur_inc  = 1'b0;
      lvl_ld    = 1'b0;
      evt_acc   = 1'b0;
      case (state_q)
         INIT: begin
            acc_start = !avm_chipselect;
            acc_wr    = 1'b1;
            acc_addr  = PIO_ADDR_MASK;
            acc_wdata = MASK_VALUE;
            if (acc_done) state_d = IDLE;
         end
         IDLE:
            if (enable && irq) begin
               state_d   = RD_CAP;
               acc_start = 1'b1;
            end
         RD_CAP: state_d = RD_CAP_W;
         RD_CAP_W:
            if (acc_done) begin
               if (acc_rdata[0]) begin
                  state_d   = RD_DAT;
                  acc_start = 1'b1;
                  acc_addr  = PIO_ADDR_DATA;
               end else begin
                  spur_inc = 1'b1;
                  state_d  = IDLE;
               end
            end
         RD_DAT: state_d = RD_DAT_W;
         RD_DAT_W:
            if (acc_done) begin
               lvl_ld    = 1'b1;
               state_d   = CLR;
               acc_start = 1'b1;
               acc_wr    = 1'b1;
               acc_wdata = CAP_CLEAR;
            end
         CLR: if (acc_done) state_d = EMIT;
         EMIT:
            if (evt_ready) begin
               evt_acc = 1'b1;
               state_d = HOLD;
            end
         HOLD: state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   // Registered status, event level and saturating counters
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         evt_valid      <= 1'b0;
         evt_level      <= 1'b0;
         evt_count      <= '0;
         spurious_count <= 8'd0;
         busy           <= 1'b1;
      end else begin
         evt_valid <= state_d == EMIT;
         busy      <= state_d != IDLE;
         if (lvl_ld) evt_level <= acc_rdata[0];
         if (evt_acc && !(&evt_count)) evt_count <= evt_count + COUNT_W'(1);
         if (spur_inc && !(&spurious_count)) spurious_count <= spurious_count + 8'd1;
      end
endmodule

// File: tb/tb_hdmi_tx_int_servicer.sv
// tb_hdmi_tx_int_servicer: directed and randomized checks of the interrupt servicer against a behavioural edge-capture PIO
module tb_hdmi_tx_int_servicer;
   localparam int          COUNT_W    = 16;
   localparam logic [31:0] MASK_VALUE = 32'h1;

   logic               clk = 1'b0, reset = 1'b1, enable = 1'b1, evt_ready = 1'b1;
   logic               irq;
   logic [1:0]         avm_address;
   logic               avm_chipselect, avm_write_n;
   logic [31:0]        avm_writedata;
   logic               evt_valid, evt_level, busy;
   logic [COUNT_W-1:0] evt_count;
   logic [7:0]         spurious_count;

   logic        int_n = 1'b1, pin_q = 1'b1, cap = 1'b0, irq_force = 1'b0, set_e, clr_e;
   logic [31:0] mask = 32'h0, rdata = 32'h0;
   int          ep = 0;
   logic        lvl_q[$];
   logic [34:0] trace[$];
   int          n_checks = 0, n_errors = 0, valid_cycles = 0;

   hdmi_tx_int_servicer #(.COUNT_W(COUNT_W), .MASK_VALUE(MASK_VALUE), .READ_LATENCY(1)) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .irq            (irq),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write_n    (avm_write_n),
      .avm_writedata  (avm_writedata),
      .avm_readdata   (rdata),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_level      (evt_level),
      .evt_count      (evt_count),
      .spurious_count (spurious_count),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   assign irq = irq_force | (cap & mask[0]);

   // Edge-capture PIO: falling INT_N sets the capture bit, writing 1 to address 3 clears it, reads are registered
   always @(posedge clk) begin
      pin_q <= int_n;
      if (avm_chipselect && avm_write_n) begin
         rdata <= (avm_address == 2'd0) ? {31'h0, int_n} : (avm_address == 2'd2) ? mask :
                  (avm_address == 2'd3) ? {31'h0, cap} : 32'h0;
         if (avm_address == 2'd0) lvl_q.push_back(int_n);
      end
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask <= avm_writedata;
      clr_e = avm_chipselect && !avm_write_n && avm_address == 2'd3 && avm_writedata[0];
      set_e = pin_q && !int_n;
      cap <= set_e ? 1'b1 : clr_e ? 1'b0 : cap;
      if (set_e && (!cap || clr_e)) ep <= ep + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bus trace and event scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      #2;
      if (avm_chipselect) trace.push_back({~avm_write_n, avm_address, avm_write_n ? 32'h0 : avm_writedata});
      if (evt_valid) valid_cycles++;
      if (evt_valid && evt_ready) begin
         check("evt_has_read", lvl_q.size() != 0, 1);
         if (lvl_q.size() != 0) check("evt_level", evt_level, lvl_q.pop_front());
      end
   end

   function automatic int count_tr(input logic w, input logic [1:0] a);
      int n = 0;
      foreach (trace[i]) if (trace[i][34] == w && trace[i][33:32] == a) n++;
      return n;
   endfunction

   task automatic wait_cs(input logic [1:0] a, input logic wr, input string tag);
      int n = 0;
      logic hit;
      do begin
         @(negedge clk);
         n++;
         hit = avm_chipselect && avm_address == a && avm_write_n == !wr;
      end while (!hit && n < 100);
      check(tag, hit, 1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!evt_valid && n < 100);
      check(tag, evt_valid, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"}, avm_address, 0);
      check({tag, "_cs"}, avm_chipselect, 0);
      check({tag, "_wn"}, avm_write_n, 1);
      check({tag, "_wdata"}, avm_writedata, 0);
      check({tag, "_valid"}, evt_valid, 0);
      check({tag, "_level"}, evt_level, 0);
      check({tag, "_count"}, evt_count, 0);
      check({tag, "_spur"}, spurious_count, 0);
      check({tag, "_busy"}, busy, 1);
   endtask

   task automatic edge_fall;
      int_n = 1'b1;
      repeat (2) @(negedge clk);
      int_n = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int v0, ep0, cnt0, sp_exp;
      int bad;
      logic lvl;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      trace.delete();
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("init_nwr", trace.size(), 1);
      check("init_wr", trace[0], {1'b1, 2'd2, MASK_VALUE});
      check("init_busy", busy, 0);

      trace.delete();
      v0 = valid_cycles;
      check("ev1_cnt0", evt_count, 0);
      int_n = 1'b0;
      wait_valid("ev1_valid");
      repeat (6) @(negedge clk);
      check("ev1_ntr", trace.size(), 3);
      check("ev1_tr0", trace[0], {1'b0, 2'd3, 32'h0});
      check("ev1_tr1", trace[1], {1'b0, 2'd0, 32'h0});
      check("ev1_tr2", trace[2], {1'b1, 2'd3, 32'h1});
      check("ev1_pulse", valid_cycles - v0, 1);
      check("ev1_level", evt_level, 0);
      check("ev1_cnt", evt_count, 1);

      evt_ready = 1'b0;
      edge_fall();
      wait_valid("bp_valid");
      trace.delete();
      lvl = evt_level;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!evt_valid || evt_level !== lvl) bad++;
      end
      check("bp_stable", bad, 0);
      check("bp_no_bus", trace.size(), 0);
      evt_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("bp_cnt", evt_count, 2);
      check("bp_valid_low", evt_valid, 0);
      check("bp_no_dup", trace.size(), 0);

      trace.delete();
      edge_fall();
      wait_cs(2'd3, 1'b0, "coal_rdcap");
      int_n = 1'b1;
      @(negedge clk);
      int_n = 1'b0;
      repeat (25) @(negedge clk);
      check("coal_cnt", evt_count, 3);
      check("coal_rd3", count_tr(1'b0, 2'd3), 1);
      check("coal_clr", count_tr(1'b1, 2'd3), 1);

      trace.delete();
      edge_fall();
      wait_cs(2'd3, 1'b1, "post_clr");
      int_n = 1'b1;
      repeat (2) @(negedge clk);
      int_n = 1'b0;
      repeat (40) @(negedge clk);
      check("post_cnt", evt_count, 5);
      check("post_clr_n", count_tr(1'b1, 2'd3), 2);

      trace.delete();
      v0 = valid_cycles;
      @(negedge clk);
      irq_force = 1'b1;
      wait_cs(2'd3, 1'b0, "spur_rd");
      irq_force = 1'b0;
      repeat (6) @(negedge clk);
      check("spur_cnt", spurious_count, 1);
      check("spur_no_clr", count_tr(1'b1, 2'd3), 0);
      check("spur_no_valid", valid_cycles - v0, 0);
      check("spur_idle", busy, 0);
      sp_exp = 1;
      repeat (259) begin
         irq_force = 1'b1;
         wait_cs(2'd3, 1'b0, "sat_rd");
         irq_force = 1'b0;
         repeat (3) @(negedge clk);
         sp_exp = (sp_exp < 255) ? sp_exp + 1 : 255;
      end
      check("spur_sat", spurious_count, sp_exp);
      check("spur_sat_evt", evt_count, 5);

      enable = 1'b0;
      edge_fall();
      trace.delete();
      repeat (15) @(negedge clk);
      check("dis_no_bus", trace.size(), 0);
      check("dis_idle", busy, 0);
      enable = 1'b1;
      wait_cs(2'd0, 1'b0, "rst_rddat");
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      lvl_q.delete();
      trace.delete();
      #1;
      check_reset_vals("mid_rst");
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("rearm_n", trace.size(), 1);
      check("rearm_wr", trace[0], {1'b1, 2'd2, MASK_VALUE});
      check("rearm_idle", busy, 0);
      enable = 1'b1;
      repeat (30) @(negedge clk);
      check("pend_cnt", evt_count, 1);
      check("pend_clr", count_tr(1'b1, 2'd3), 1);

      ep0 = ep;
      cnt0 = int'(evt_count);
      repeat (800) begin
         @(negedge clk);
         if ($urandom_range(7) == 0) int_n = ~int_n;
         evt_ready = 1'($urandom_range(1));
         enable = $urandom_range(9) != 0;
      end
      enable = 1'b1;
      evt_ready = 1'b1;
      repeat (60) @(negedge clk);
      check("rnd_events", int'(evt_count) - cnt0, ep - ep0);
      check("rnd_spur", spurious_count, 0);
      check("rnd_pending", lvl_q.size(), 0);
      check("rnd_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
